// File: rtl/stream_buf_ctrl.sv
// Ring-buffer controller for the valid-tagged dual-port slot memory: stream in on port A, read/clear on port B, stream out.
// Optional build macro STREAM_BUF_VLD_CHECK_EN enables checking of the slot valid bit on read, plus the sticky err flag.
module stream_buf_ctrl #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_ADDR_BITS = 6
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PAYLOAD_BITS-1:0]   din,
  input  logic                      din_vld,
  output logic                      din_rdy,
  output logic [PAYLOAD_BITS-1:0]   dout,
  output logic                      dout_vld,
  input  logic                      dout_rdy,
  output logic                      wea,
  output logic [NUM_ADDR_BITS-1:0]  addra,
  output logic [PAYLOAD_BITS:0]     dina,
  output logic                      web,
  output logic [NUM_ADDR_BITS-1:0]  addrb,
  output logic [PAYLOAD_BITS:0]     dinb,
  input  logic [PAYLOAD_BITS:0]     doutb,
  output logic                      err
);

  localparam int DEPTH = 2 ** NUM_ADDR_BITS;
  localparam logic [NUM_ADDR_BITS:0]   DEPTH_C = (NUM_ADDR_BITS + 1)'(DEPTH);
  localparam logic [NUM_ADDR_BITS:0]   CNT_ONE = (NUM_ADDR_BITS + 1)'(1);
  localparam logic [NUM_ADDR_BITS:0]   CNT_ZERO = (NUM_ADDR_BITS + 1)'(0);
  localparam logic [NUM_ADDR_BITS-1:0] PTR_ONE = NUM_ADDR_BITS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CLR  = 2'd2
  } state_t;

  state_t                    state_r;
  logic [NUM_ADDR_BITS-1:0]  wr_ptr_r;
  logic [NUM_ADDR_BITS-1:0]  rd_ptr_r;
  logic [NUM_ADDR_BITS:0]    count_r;
  logic [NUM_ADDR_BITS:0]    count_nxt_s;
  logic [PAYLOAD_BITS-1:0]   dout_r;
  logic                      dout_vld_r;
  logic                      web_r;
  logic                      accept_s;
  logic                      capture_s;
  logic                      slot_ok_s;
  logic                      out_free_s;
  logic                      start_s;

`ifdef STREAM_BUF_VLD_CHECK_EN
  logic err_r;
  assign slot_ok_s = doutb[PAYLOAD_BITS];
  assign err       = err_r;

  // Sticky flag: a slot read back without its valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_CLR) && !slot_ok_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  logic unused_vld_s;
  assign unused_vld_s = doutb[PAYLOAD_BITS];
  assign slot_ok_s    = 1'b1;
  assign err          = 1'b0;
`endif

  assign din_rdy    = (count_r != DEPTH_C);
  assign accept_s   = din_vld & din_rdy;
  assign capture_s  = (state_r == ST_CLR) & slot_ok_s;
  assign out_free_s = ~dout_vld_r | dout_rdy;
  // Uses the post-update count so a word accepted this cycle starts its read next cycle.
  assign start_s    = (count_nxt_s != CNT_ZERO) & out_free_s;

  assign wea   = accept_s;
  assign addra = wr_ptr_r;
  assign dina  = {1'b1, din};
  assign web   = web_r;
  assign addrb = rd_ptr_r;
  assign dinb  = {(PAYLOAD_BITS + 1){1'b0}};
  assign dout     = dout_r;
  assign dout_vld = dout_vld_r;

  // Occupancy after this cycle's accept and capture; both at once leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({accept_s, capture_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, output register and the read FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      wr_ptr_r   <= {NUM_ADDR_BITS{1'b0}};
      rd_ptr_r   <= {NUM_ADDR_BITS{1'b0}};
      count_r    <= CNT_ZERO;
      dout_r     <= {PAYLOAD_BITS{1'b0}};
      dout_vld_r <= 1'b0;
      web_r      <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (accept_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (capture_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        dout_r     <= doutb[PAYLOAD_BITS-1:0];
        dout_vld_r <= 1'b1;
      end else if (dout_vld_r && dout_rdy) begin
        dout_vld_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          web_r <= 1'b0;
          if (start_s) begin
            state_r <= ST_RD;
          end
        end
        // Hold the read until the output register is certain to be free at the capture.
        ST_RD: begin
          if (out_free_s) begin
            state_r <= ST_CLR;
            web_r   <= 1'b1;
          end else begin
            web_r   <= 1'b0;
          end
        end
        ST_CLR: begin
          web_r <= 1'b0;
          if (!slot_ok_s) begin
            state_r <= ST_RD;
          end else if (start_s) begin
            state_r <= ST_RD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          web_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_buf_ctrl.sv
// Self-checking bench for stream_buf_ctrl with a behavioural valid-tagged slot memory and an in-order scoreboard.
module tb_stream_buf_ctrl;
  localparam int PB = 32;
  localparam int AB = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [PB-1:0] din;
  logic          din_vld;
  logic          din_rdy;
  logic [PB-1:0] dout;
  logic          dout_vld;
  logic          dout_rdy;
  logic          wea;
  logic [AB-1:0] addra;
  logic [PB:0]   dina;
  logic          web;
  logic [AB-1:0] addrb;
  logic [PB:0]   dinb;
  logic [PB:0]   doutb;
  logic          err;

  logic [PB:0]   mem [DEPTH];
  logic [PB:0]   doutb_r;
  logic          inj = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [PB-1:0] exp_q [$];
  int out_t [$];

  typedef struct {
    logic [PB-1:0] din;
    logic [AB-1:0] addr;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  stream_buf_ctrl #(.PAYLOAD_BITS(PB), .NUM_ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .wea(wea), .addra(addra), .dina(dina), .web(web), .addrb(addrb),
    .dinb(dinb), .doutb(doutb), .err(err)
  );

  assign doutb = doutb_r;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Slot memory model: 1-cycle read latency, valid bits flushed on reset.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i][PB] <= 1'b0;
      doutb_r <= '0;
    end else begin
      if (wea) mem[addra] <= dina;
      if (web) mem[addrb] <= dinb;
      doutb_r <= mem[addrb];
      if (inj) doutb_r[PB] <= 1'b0;
    end
  end

  // Scoreboard and same-address collision check.
  always @(negedge clk) begin
    if (!reset) begin
      if (din_vld && din_rdy) exp_q.push_back(din);
      if (dout_vld && dout_rdy) begin
        out_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none", dout);
        end else begin
          chk("sb_order", dout, exp_q.pop_front());
        end
      end
      if (wea && web) chk("ab_collision", (addra == addrb), 1'b0);
    end
  end

  task automatic stream(input int n, input int base, input bit rnd_in, input bit rnd_out, input int bound);
    int sent = 0;
    int c = 0;
    while (sent < n && c < bound) begin
      @(posedge clk); #1;
      din_vld = rnd_in ? 1'($urandom_range(0, 1)) : 1'b1;
      din = base + sent;
      if (rnd_out) dout_rdy = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (din_vld && din_rdy) sent++;
      c++;
    end
    @(posedge clk); #1;
    din_vld = 1'b0;
    chk("stream_sent", sent, n);
  endtask

  task automatic drain(input int bound);
    int c = 0;
    dout_rdy = 1'b1;
    while (c < bound && (exp_q.size() != 0 || dout_vld)) begin
      @(negedge clk);
      c++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_vld", dout_vld, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'hA5A5_0001, 6'd0};
    vecs[1] = '{32'hFFFF_FFFF, 6'd1};
    vecs[2] = '{32'h0000_0000, 6'd2};
    vecs[3] = '{32'h8000_0001, 6'd3};

    reset = 1'b1; din = '0; din_vld = 1'b0; dout_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_din_rdy", din_rdy, 1'b1);
    chk("rst_dout_vld", dout_vld, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_wea_web", {wea, web}, 2'b00);

    // Single-word latency, one vector per record.
    for (int v = 0; v < 4; v++) begin
      @(posedge clk); #1;
      din = vecs[v].din; din_vld = 1'b1;
      @(negedge clk);
      chk("c0_wea", wea, 1'b1);
      chk("c0_addra", addra, vecs[v].addr);
      chk("c0_dina", dina, {1'b1, vecs[v].din});
      @(posedge clk); #1;
      din_vld = 1'b0;
      @(negedge clk);
      chk("c1_addrb", addrb, vecs[v].addr);
      chk("c1_web", web, 1'b0);
      @(negedge clk);
      chk("c2_web", web, 1'b1);
      chk("c2_addrb", addrb, vecs[v].addr);
      chk("c2_dinb", dinb, 33'h0);
      @(negedge clk);
      chk("c3_dout_vld", dout_vld, 1'b1);
      chk("c3_dout", dout, vecs[v].din);
      @(negedge clk);
      chk("c4_dout_vld", dout_vld, 1'b0);
    end

    // Fill until full with the output stalled: 64 slots plus the held output word.
    begin
      int n = 0;
      int c = 0;
      dout_rdy = 1'b0;
      while (c < 100) begin
        @(posedge clk); #1;
        din_vld = 1'b1; din = 32'h1000_0000 + n;
        @(negedge clk);
        c++;
        if (din_rdy) n++;
        else break;
      end
      chk("full_accepts", n, DEPTH + 1);
      chk("full_wea", wea, 1'b0);
      chk("full_dout", {dout_vld, dout}, {1'b1, 32'h1000_0000});
      @(posedge clk); #1;
      din_vld = 1'b0;
      repeat (4) @(negedge clk);
      chk("full_hold", din_rdy, 1'b0);
      drain(400);
    end

    // Continuous stream: 200 words, steady output every 2 cycles.
    out_t.delete();
    dout_rdy = 1'b1;
    stream(200, 32'h2000_0000, 1'b0, 1'b0, 1000);
    drain(1000);
    chk("stream_count", out_t.size(), 200);
    if (out_t.size() >= 110) chk("stream_rate", out_t[109] - out_t[9], 200);

    // Random handshakes on both sides.
    stream(80, 32'h3000_0000, 1'b1, 1'b1, 2000);
    drain(400);

    // Reset with words buffered and the output valid.
    dout_rdy = 1'b0;
    stream(10, 32'h4000_0000, 1'b0, 1'b0, 50);
    repeat (3) @(negedge clk);
    chk("pre_rst_vld", dout_vld, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_vld", dout_vld, 1'b0);
    chk("mid_rst_rdy", din_rdy, 1'b1);
    @(posedge clk); #1;
    din = 32'h0000_0BAD; din_vld = 1'b1; dout_rdy = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    begin
      int c = 0;
      while (c < 10 && !dout_vld) begin
        @(negedge clk);
        c++;
      end
      chk("post_rst_first", {dout_vld, dout}, {1'b1, 32'h0000_0BAD});
    end
    drain(50);

`ifdef STREAM_BUF_VLD_CHECK_EN
    // Corrupted valid bit on read sets the sticky error.
    inj = 1'b1;
    @(posedge clk); #1;
    din = 32'h5000_0001; din_vld = 1'b1;
    @(posedge clk); #1;
    din_vld = 1'b0;
    repeat (6) @(negedge clk);
    chk("vld_err_set", err, 1'b1);
    inj = 1'b0;
    repeat (6) @(negedge clk);
    chk("vld_err_sticky", err, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("vld_err_clear", err, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
